// File: rtl/fifo_rd_drain_if.sv
// Bundle of the FIFO read port, the drain control and the output stream
// for fifo_rd_drain. The master modport is the drain block itself; the
// slave modport is its environment (the FIFO read side plus the stream sink).
// FIFO_POP_CNT_EN adds the pop_count signal and its CNT_W parameter.
interface fifo_rd_drain_if #(
  parameter int WIDTH = 8
`ifdef FIFO_POP_CNT_EN
  , parameter int CNT_W = 16
`endif
);

  logic             empty;
  logic [WIDTH-1:0] data_out;
  logic             pop;
  logic             drain_en;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             busy;
`ifdef FIFO_POP_CNT_EN
  logic [CNT_W-1:0] pop_count;
`endif

  modport master (
    input  empty, data_out, drain_en, s_ready,
    output pop, s_valid, s_data, busy
`ifdef FIFO_POP_CNT_EN
    , output pop_count
`endif
  );

  modport slave (
    output empty, data_out, drain_en, s_ready,
    input  pop, s_valid, s_data, busy
`ifdef FIFO_POP_CNT_EN
    , input pop_count
`endif
  );

endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer of the async FIFO in the rdclk domain.
// Pops the FIFO while it is non-empty and there is room for the word, and
// replays the words on a valid/ready stream at up to one word per cycle.
// The FIFO read latency (RD_LAT, 1 or 2) is hidden by a skid buffer of
// RD_LAT+1 entries; a valid-bit pipe tracks words popped but not yet
// returned by the FIFO. s_data always comes from a register, never from
// data_out directly.
// Optional feature macro: FIFO_POP_CNT_EN adds a wrapping CNT_W-bit pop
// counter on pop_count; without it the counter and port do not exist.
module fifo_rd_drain #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
`ifdef FIFO_POP_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            rdclk,
  input  logic            rd_rst,
  fifo_rd_drain_if.master bus
);

  localparam int BUF_DEPTH = RD_LAT + 1;
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0]  mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]  headPtr_q, headPtr_d;
  logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic              capture;
  logic              deq;
  logic              sValid;
  logic              popReq;
  int                pending;

`ifdef FIFO_POP_CNT_EN
  logic [CNT_W-1:0]  popCnt_q, popCnt_d;
`endif

  // Circular pointer advance, wrapping at the last buffer entry.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Pop decision and next-state for pointers, occupancy and the in-flight pipe.
  always_comb begin
    sValid     = (occ_q != '0);
    deq        = sValid & bus.s_ready;
    capture    = inflight_q[RD_LAT-1];
    pending    = int'(occ_q) + $countones(inflight_q) - int'(deq);
    popReq     = !rd_rst & !bus.empty & bus.drain_en & (pending < BUF_DEPTH);
    inflight_d = (inflight_q << 1) | RD_LAT'(popReq);
    tailPtr_d  = capture ? nextPtr(tailPtr_q) : tailPtr_q;
    headPtr_d  = deq ? nextPtr(headPtr_q) : headPtr_q;
    occ_d      = occ_q;
    if (capture && !deq) begin
      occ_d = occ_q + 1'b1;
    end else if (!capture && deq) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Skid buffer storage and control registers; reset flushes everything in flight.
  always_ff @(posedge rdclk or posedge rd_rst) begin
    if (rd_rst) begin
      headPtr_q  <= '0;
      tailPtr_q  <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      if (capture) begin
        mem_q[tailPtr_q] <= bus.data_out;
      end
    end
  end

`ifdef FIFO_POP_CNT_EN
  // Next value of the free-running pop counter; wraps naturally at 2^CNT_W.
  always_comb begin
    popCnt_d = popCnt_q + CNT_W'(popReq);
  end

  // Pop counter register.
  always_ff @(posedge rdclk or posedge rd_rst) begin
    if (rd_rst) begin
      popCnt_q <= '0;
    end else begin
      popCnt_q <= popCnt_d;
    end
  end

  assign bus.pop_count = popCnt_q;
`endif

  assign bus.pop     = popReq;
  assign bus.s_valid = sValid;
  assign bus.s_data  = mem_q[headPtr_q];
  assign bus.busy    = sValid | (inflight_q != '0);

  // The room check guarantees a returning word always finds a free entry.
  a_noOverflow : assert property (@(posedge rdclk) disable iff (rd_rst)
    capture |-> (occ_q != OCC_W'(BUF_DEPTH)));

  // The block must never strobe an empty FIFO.
  a_noUnderflow : assert property (@(posedge rdclk) disable iff (rd_rst)
    popReq |-> !bus.empty);

endmodule
